// File: rtl/hbs_pkg.sv
// Shared sizing helpers for the high-bit search unit and its leading-one tree.
package hbs_pkg;

    localparam int HBS_DEFAULT_WIDTH = 8;

    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Tree is built over the next power of two; bits above the word's MSB are tied to zero.
    function automatic int pad_width(input int w);
        return 1 << idx_width(w);
    endfunction

    localparam int HBS_DEFAULT_PAD_WIDTH = pad_width(HBS_DEFAULT_WIDTH);

endpackage

// File: rtl/hbs_lod_node.sv
// Recursive leading-one node: splits its word in halves and merges their (valid, index) pairs.
module hbs_lod_node #(
    parameter  int W  = 2,
    localparam int IW = $clog2(W)
) (
    input  logic [W-1:0]  data_i,
    output logic          vld_o,
    output logic [IW-1:0] idx_o
);

    if (W == 2) begin : g_leaf
        assign vld_o = |data_i;
        assign idx_o = data_i[1];
    end else begin : g_merge
        logic          hi_vld;
        logic          lo_vld;
        logic [IW-2:0] hi_idx;
        logic [IW-2:0] lo_idx;

        hbs_lod_node #(.W(W/2)) u_hi (
            .data_i (data_i[W-1:W/2]),
            .vld_o  (hi_vld),
            .idx_o  (hi_idx)
        );

        hbs_lod_node #(.W(W/2)) u_lo (
            .data_i (data_i[W/2-1:0]),
            .vld_o  (lo_vld),
            .idx_o  (lo_idx)
        );

        // Upper half has priority; its valid bit becomes the new index MSB.
        assign vld_o = hi_vld | lo_vld;
        assign idx_o = {hi_vld, hi_vld ? hi_idx : lo_idx};
    end

endmodule

// File: rtl/high_bit_search_unit.sv
// Two-stage registered leading-one detector: input register, LOD tree, registered index/onehot/found.
module high_bit_search_unit
    import hbs_pkg::*;
#(
    parameter  int INPUT_WIDTH = HBS_DEFAULT_WIDTH,
    localparam int IDX_WIDTH   = idx_width(INPUT_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] input_data,
    output logic [IDX_WIDTH-1:0]   high_bit_index,
    output logic [INPUT_WIDTH-1:0] high_bit_onehot,
    output logic                   found
);

    localparam int PAD_WIDTH = pad_width(INPUT_WIDTH);

    logic [INPUT_WIDTH-1:0] data_q;
    logic [PAD_WIDTH-1:0]   data_pad;
    logic                   found_d;
    logic [IDX_WIDTH-1:0]   idx_d;
    logic [INPUT_WIDTH-1:0] onehot_d;
    logic                   found_q;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [INPUT_WIDTH-1:0] onehot_q;

    // Zero-extension keeps the pad bits from ever winning the search.
    assign data_pad = PAD_WIDTH'(data_q);

    hbs_lod_node #(.W(PAD_WIDTH)) u_tree (
        .data_i (data_pad),
        .vld_o  (found_d),
        .idx_o  (idx_d)
    );

    assign onehot_d = found_d ? (INPUT_WIDTH'(1) << idx_d) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            found_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            data_q   <= input_data;
            found_q  <= found_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign high_bit_index  = idx_q;
    assign high_bit_onehot = onehot_q;
    assign found           = found_q;

endmodule

// File: tb/tb_high_bit_search_unit.sv
// Directed table-driven bench for the high-bit search unit at widths 8 and 13.
module tb_high_bit_search_unit;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  idx;
        logic [15:0] oh;
        logic        fnd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in8 = '0;
    logic [2:0]  idx8;
    logic [7:0]  oh8;
    logic        fnd8;
    logic [12:0] in13 = '0;
    logic [3:0]  idx13;
    logic [12:0] oh13;
    logic        fnd13;

    int vec_cnt = 0;
    int miscmp  = 0;

    vec_t t8[$];
    vec_t t13[$];

    high_bit_search_unit #(.INPUT_WIDTH(8)) u_dut8 (
        .clk             (clk),
        .rst             (rst),
        .input_data      (in8),
        .high_bit_index  (idx8),
        .high_bit_onehot (oh8),
        .found           (fnd8)
    );

    high_bit_search_unit #(.INPUT_WIDTH(13)) u_dut13 (
        .clk             (clk),
        .rst             (rst),
        .input_data      (in13),
        .high_bit_index  (idx13),
        .high_bit_onehot (oh13),
        .found           (fnd13)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] din, input logic [3:0] idx,
                                input logic [15:0] oh, input logic fnd);
        vec_t v;
        v.din = din;
        v.idx = idx;
        v.oh  = oh;
        v.fnd = fnd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check8(input string nm, input logic [3:0] idx, input logic [15:0] oh, input logic fnd);
        check({nm, " idx"},   16'(idx8), 16'(idx));
        check({nm, " oh"},    16'(oh8),  oh);
        check({nm, " found"}, 16'(fnd8), 16'(fnd));
    endtask

    task automatic check13(input string nm, input logic [3:0] idx, input logic [15:0] oh, input logic fnd);
        check({nm, " idx"},   16'(idx13), 16'(idx));
        check({nm, " oh"},    16'(oh13),  oh);
        check({nm, " found"}, 16'(fnd13), 16'(fnd));
    endtask

    initial begin
        // Streaming MSB-set words
        t8.push_back(mk(16'hDE, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hAD, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hBE, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hEF, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hCA, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hFE, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hBA, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hBA, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hDE, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'hDA, 4'd7, 16'h80, 1'b1));
        // Walking one, then zero
        t8.push_back(mk(16'h01, 4'd0, 16'h01, 1'b1));
        t8.push_back(mk(16'h02, 4'd1, 16'h02, 1'b1));
        t8.push_back(mk(16'h04, 4'd2, 16'h04, 1'b1));
        t8.push_back(mk(16'h08, 4'd3, 16'h08, 1'b1));
        t8.push_back(mk(16'h10, 4'd4, 16'h10, 1'b1));
        t8.push_back(mk(16'h20, 4'd5, 16'h20, 1'b1));
        t8.push_back(mk(16'h40, 4'd6, 16'h40, 1'b1));
        t8.push_back(mk(16'h80, 4'd7, 16'h80, 1'b1));
        t8.push_back(mk(16'h00, 4'd0, 16'h00, 1'b0));
        // Mixed words
        t8.push_back(mk(16'h10, 4'd4, 16'h10, 1'b1));
        t8.push_back(mk(16'h3F, 4'd5, 16'h20, 1'b1));
        t8.push_back(mk(16'h05, 4'd2, 16'h04, 1'b1));
        t8.push_back(mk(16'h02, 4'd1, 16'h02, 1'b1));

        t13.push_back(mk(16'h1000, 4'd12, 16'h1000, 1'b1));
        t13.push_back(mk(16'h0003, 4'd1,  16'h0002, 1'b1));
        t13.push_back(mk(16'h0000, 4'd0,  16'h0000, 1'b0));
        t13.push_back(mk(16'h1FFF, 4'd12, 16'h1000, 1'b1));
        t13.push_back(mk(16'h0100, 4'd8,  16'h0100, 1'b1));
        t13.push_back(mk(16'h0801, 4'd11, 16'h0800, 1'b1));

        // Reset held for 3 edges with all-ones input
        rst  = 1'b1;
        in8  = 8'hFF;
        in13 = 13'h1FFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check8($sformatf("reset8[%0d]", i), 4'd0, 16'h0, 1'b0);
            check13($sformatf("reset13[%0d]", i), 4'd0, 16'h0, 1'b0);
        end

        // First word after release appears two edges later
        rst  = 1'b0;
        in8  = 8'h01;
        in13 = 13'h0;
        @(posedge clk); #1;
        check8("release edge1", 4'd0, 16'h0, 1'b0);
        @(posedge clk); #1;
        check8("release edge2", 4'd0, 16'h01, 1'b1);

        // Back-to-back table: word i is sampled at edge i, checked after edge i+1
        for (int i = 0; i <= t8.size(); i++) begin
            in8 = (i < t8.size()) ? t8[i].din[7:0] : 8'h00;
            @(posedge clk); #1;
            if (i > 0)
                check8($sformatf("w8[%0d]", i - 1), t8[i-1].idx, t8[i-1].oh, t8[i-1].fnd);
        end

        // Mid-stream reset discards 0x40 (in data_q) and clears outputs
        in8 = 8'h80;
        @(posedge clk); #1;
        in8 = 8'h40;
        @(posedge clk); #1;
        check8("pre-reset 0x80", 4'd7, 16'h80, 1'b1);
        rst = 1'b1;
        in8 = 8'hFF;
        @(posedge clk); #1;
        check8("midreset edge", 4'd0, 16'h0, 1'b0);
        rst = 1'b0;
        in8 = 8'h22;
        @(posedge clk); #1;
        check8("midreset no holdover", 4'd0, 16'h0, 1'b0);
        in8 = 8'h00;
        @(posedge clk); #1;
        check8("midreset new data", 4'd5, 16'h20, 1'b1);

        // Odd width: padded tree must stay below bit 13
        for (int i = 0; i <= t13.size(); i++) begin
            in13 = (i < t13.size()) ? t13[i].din[12:0] : 13'h0;
            @(posedge clk); #1;
            if (i > 0)
                check13($sformatf("w13[%0d]", i - 1), t13[i-1].idx, t13[i-1].oh, t13[i-1].fnd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
